// File: rtl/overlay_pkg.sv
// Shared types and constants for the overlay fetch path: pixel layout,
// fetch FSM states and the default FIFO depth.
package overlay_pkg;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] g;
        logic [3:0] r;
    } rgba4_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } fetch_state_t;

    // Bit offsets of the even and odd pixel inside one 32-bit SDRAM read.
    localparam int LO_HALF            = 0;
    localparam int HI_HALF            = 16;
    localparam int DEFAULT_FIFO_DEPTH = 8;

    function automatic rgba4_t to_rgba(input logic [15:0] word);
        return rgba4_t'(word);
    endfunction

endpackage

// File: rtl/overlay_fifo.sv
// 16-bit pixel FIFO with a dual-entry push port (first entry lands first),
// a single pop port and a flush that empties it in one clock.
module overlay_fifo
    import overlay_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [1:0]               push_cnt,
    input  logic [15:0]              push_first,
    input  logic [15:0]              push_second,
    input  logic                     pop,
    output logic [15:0]              head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign head = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_cnt != 2'd0) mem[wr_ptr] <= push_first;
        if (push_cnt == 2'd2) mem[wr_ptr + AW'(1)] <= push_second;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_cnt);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_cnt) - CW'(pop);
        end
    end

endmodule

// File: rtl/overlay_fetch.sv
// Streams the RGBA4444 overlay from SDRAM channel 1 into the mixer: a request
// FSM keeps a small pixel FIFO topped up and pops one pixel per active strobe.
module overlay_fetch
    import overlay_pkg::*;
#(
    parameter int          RD_LAT     = 2,
    parameter int          FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter logic [23:0] BASE_ADDR  = 24'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        ce_pix,
    input  logic        hblank,
    input  logic        vblank,
    input  logic        vsync,
    output logic        sd_req,
    output logic [23:0] sd_addr,
    input  logic [31:0] sd_data,
    output logic [3:0]  bg_r,
    output logic [3:0]  bg_g,
    output logic [3:0]  bg_b,
    output logic [3:0]  bg_a,
    output logic        underrun
);
    localparam int          CW         = $clog2(FIFO_DEPTH) + 1;
    localparam int          LW         = $clog2(RD_LAT + 1);
    localparam logic [23:0] START_ADDR = {BASE_ADDR[23:1], 1'b0};

    fetch_state_t  state;
    logic [LW-1:0] lat_cnt;
    logic          discard;
    logic          armed;
    logic          vsync_prev;
    logic [CW-1:0] count;
    logic [CW-1:0] debt;
    logic [CW-1:0] debt_next;
    logic [15:0]   head;
    rgba4_t        bg;

    logic          frame_start;
    logic          flush;
    logic          capture;
    logic          push_ok;
    logic          pop_en;
    logic          fifo_empty;
    logic          starve;
    logic          fifo_pop;
    logic          req_go;
    logic [1:0]    drops;
    logic [1:0]    push_cnt;
    logic [15:0]   push_first;
    logic [15:0]   push_second;

    assign frame_start = ce_pix & vsync & ~vsync_prev;
    assign flush       = frame_start | ~enable;
    assign capture     = (state == ST_WAIT) && (lat_cnt == LW'(RD_LAT));
    assign push_ok     = capture & ~discard & ~flush;
    assign pop_en      = ce_pix & ~hblank & ~vblank & enable;
    assign fifo_empty  = (count == '0);
    assign starve      = pop_en & fifo_empty;
    assign fifo_pop    = pop_en & ~fifo_empty;
    // Occupancy is the pre-pop count, so a request never overfills the FIFO.
    assign req_go      = (state == ST_IDLE) && enable && armed && !flush &&
                         ((CW'(FIFO_DEPTH) - count) >= CW'(2));

    // Pixels starved earlier in the frame are owed: the matching entries of the
    // next reads are dropped so every pixel keeps its screen position.
    always_comb begin
        drops = 2'd0;
        if (push_ok) drops = (debt >= CW'(2)) ? 2'd2 : debt[1:0];
        push_cnt    = push_ok ? (2'd2 - drops) : 2'd0;
        push_first  = (drops == 2'd0) ? sd_data[LO_HALF +: 16] : sd_data[HI_HALF +: 16];
        push_second = sd_data[HI_HALF +: 16];
        debt_next   = debt - CW'(drops);
        if (starve && (debt_next != CW'(FIFO_DEPTH))) debt_next = debt_next + CW'(1);
    end

    overlay_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .push_cnt    (push_cnt),
        .push_first  (push_first),
        .push_second (push_second),
        .pop         (fifo_pop),
        .head        (head),
        .count       (count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            lat_cnt <= '0;
            sd_req  <= 1'b0;
            sd_addr <= START_ADDR;
            discard <= 1'b0;
            armed   <= 1'b0;
        end else begin
            sd_req <= 1'b0;
            // A restart during an outstanding read lets the read finish unused.
            if (flush && (state == ST_REQ || (state == ST_WAIT && !capture)))
                discard <= 1'b1;
            else if (capture)
                discard <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_go) begin
                        state  <= ST_REQ;
                        sd_req <= 1'b1;
                    end
                end
                ST_REQ: begin
                    state   <= ST_WAIT;
                    lat_cnt <= LW'(1);
                end
                ST_WAIT: begin
                    if (capture) state <= ST_IDLE;
                    else         lat_cnt <= lat_cnt + LW'(1);
                end
                default: state <= ST_IDLE;
            endcase
            if (frame_start)
                sd_addr <= START_ADDR;
            else if (state == ST_REQ)
                sd_addr <= sd_addr + 24'd2;
            if (!enable)
                armed <= 1'b0;
            else if (frame_start)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_prev <= 1'b0;
            bg         <= '0;
            underrun   <= 1'b0;
            debt       <= '0;
        end else begin
            if (ce_pix) vsync_prev <= vsync;
            if (pop_en)
                bg <= fifo_empty ? rgba4_t'('0) : to_rgba(head);
            else if (ce_pix)
                bg <= '0;
            if (frame_start)
                underrun <= 1'b0;
            else if (starve)
                underrun <= 1'b1;
            debt <= flush ? '0 : debt_next;
        end
    end

    assign bg_r = enable ? bg.r : 4'd0;
    assign bg_g = enable ? bg.g : 4'd0;
    assign bg_b = enable ? bg.b : 4'd0;
    assign bg_a = enable ? bg.a : 4'd0;

endmodule

// File: tb/tb_overlay_fetch.sv
// Directed bench for overlay_fetch with a fixed-latency SDRAM read model that
// returns {addr+1, addr} for each request.
module tb_overlay_fetch;

    localparam int LAT = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        ce_pix;
    logic        hblank;
    logic        vblank;
    logic        vsync;
    logic        sd_req;
    logic [23:0] sd_addr;
    logic [31:0] sd_data;
    logic [3:0]  bg_r;
    logic [3:0]  bg_g;
    logic [3:0]  bg_b;
    logic [3:0]  bg_a;
    logic        underrun;
    logic [15:0] bg_word;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign bg_word = {bg_a, bg_b, bg_g, bg_r};

    overlay_fetch #(
        .RD_LAT     (LAT),
        .FIFO_DEPTH (8),
        .BASE_ADDR  (24'h000000)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .ce_pix   (ce_pix),
        .hblank   (hblank),
        .vblank   (vblank),
        .vsync    (vsync),
        .sd_req   (sd_req),
        .sd_addr  (sd_addr),
        .sd_data  (sd_data),
        .bg_r     (bg_r),
        .bg_g     (bg_g),
        .bg_b     (bg_b),
        .bg_a     (bg_a),
        .underrun (underrun)
    );

    // SDRAM read model: data for a request appears LAT clocks after sd_req.
    logic [23:0] pipe_addr [LAT];
    logic        pipe_vld  [LAT];
    logic [23:0] req_log [$];
    logic [15:0] ret_lo;

    always @(posedge clk) begin
        if (sd_req) req_log.push_back(sd_addr);
        pipe_vld[0]  <= sd_req;
        pipe_addr[0] <= sd_addr;
        for (int i = 1; i < LAT; i++) begin
            pipe_vld[i]  <= pipe_vld[i-1];
            pipe_addr[i] <= pipe_addr[i-1];
        end
    end

    assign ret_lo  = pipe_addr[LAT-1][15:0];
    assign sd_data = (pipe_vld[LAT-1] === 1'b1) ? {ret_lo + 16'd1, ret_lo} : 32'hDEAD_BEEF;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] req_at(input int idx);
        if (idx < req_log.size()) return req_log[idx];
        return 24'hFFFFFF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        ce_pix = 1'b0;
        repeat (n) tick();
    endtask

    task automatic pop_px(output logic [15:0] v);
        ce_pix = 1'b1;
        hblank = 1'b0;
        vblank = 1'b0;
        tick();
        ce_pix = 1'b0;
        v = bg_word;
    endtask

    // snap is the request count just after the frame-start edge.
    task automatic frame(output int snap);
        ce_pix = 1'b1;
        vblank = 1'b1;
        hblank = 1'b0;
        vsync  = 1'b0;
        tick();
        vsync = 1'b1;
        tick();
        snap = req_log.size();
        tick();
        vsync = 1'b0;
        tick();
        ce_pix = 1'b0;
        vblank = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] px;
        int          snap;
        int          found;

        reset  = 1'b1;
        enable = 1'b0;
        ce_pix = 1'b0;
        hblank = 1'b0;
        vblank = 1'b0;
        vsync  = 1'b0;
        tick();
        tick();
        check("rst_sd_req", sd_req, 0);
        check("rst_sd_addr", sd_addr, 0);
        check("rst_bg", bg_word, 0);
        check("rst_underrun", underrun, 0);
        reset  = 1'b0;
        enable = 1'b1;
        idle(20);
        check("no_req_before_vsync", req_log.size(), 0);

        // Frame start with blank held: fill to full, addresses 0,2,4,6.
        frame(snap);
        idle(100);
        check("full_req_count", req_log.size() - snap, 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("req_addr%0d", i), req_at(snap + i), 2 * i);
        pop_px(px);
        check("px0", px, 16'h0000);
        idle(40);
        check("full_hold_after_one_pop", req_log.size() - snap, 4);
        pop_px(px);
        check("px1", px, 16'h0001);
        idle(40);
        check("refill_req_count", req_log.size() - snap, 5);
        check("refill_addr", req_at(snap + 4), 24'd8);
        for (int n = 2; n < 6; n++) begin
            pop_px(px);
            check($sformatf("px%0d", n), px, n);
            idle(2);
        end

        // Underrun: six back-to-back pixels right after frame start all starve.
        idle(60);
        frame(snap);
        for (int n = 0; n < 6; n++) begin
            pop_px(px);
            check($sformatf("starved_px%0d", n), px, 0);
            check($sformatf("underrun_px%0d", n), underrun, 1);
        end
        idle(80);
        for (int n = 6; n < 14; n++) begin
            pop_px(px);
            check($sformatf("aligned_px%0d", n), px, n);
        end
        check("underrun_sticky", underrun, 1);

        // vsync edge one clock after sd_req, while the read is outstanding.
        found = 0;
        for (int i = 0; i < 60 && found == 0; i++) begin
            tick();
            if (sd_req) found = 1;
        end
        check("midwait_req_seen", found, 1);
        check("underrun_before_restart", underrun, 1);
        tick();
        vblank = 1'b1;
        vsync  = 1'b1;
        ce_pix = 1'b1;
        tick();
        snap  = req_log.size();
        vsync = 1'b0;
        tick();
        ce_pix = 1'b0;
        vblank = 1'b0;
        check("underrun_cleared", underrun, 0);
        idle(100);
        check("restart_req_count", req_log.size() - snap, 4);
        check("restart_addr", req_at(snap), 24'd0);
        for (int n = 0; n < 3; n++) begin
            pop_px(px);
            check($sformatf("restart_px%0d", n), px, n);
            idle(2);
        end

        // enable low mid-line.
        pop_px(px);
        check("pre_disable_px", px, 16'h0003);
        enable = 1'b0;
        #1;
        check("disable_bg_immediate", bg_word, 0);
        tick();
        snap = req_log.size();
        idle(20);
        pop_px(px);
        check("disabled_px", px, 0);
        check("disabled_no_underrun", underrun, 0);
        idle(20);
        check("disabled_no_req", req_log.size() - snap, 0);
        enable = 1'b1;
        idle(40);
        check("no_req_until_vsync", req_log.size() - snap, 0);
        frame(snap);
        idle(100);
        check("enable_restart_count", req_log.size() - snap, 4);
        check("enable_restart_addr", req_at(snap), 24'd0);
        pop_px(px);
        check("enable_restart_px0", px, 16'h0000);

        // Async reset between clock edges with a request on the bus.
        for (int i = 0; i < 20; i++) pop_px(px);
        check("burst_underrun", underrun, 1);
        idle(100);
        pop_px(px);
        pop_px(px);
        check("pre_reset_bg_nonzero", (bg_word != 16'h0000), 1);
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            if (sd_req) found = 1;
            else tick();
        end
        check("pre_reset_req", found, 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_sd_req", sd_req, 0);
        check("async_rst_bg", bg_word, 0);
        check("async_rst_underrun", underrun, 0);
        check("async_rst_sd_addr", sd_addr, 0);
        tick();
        reset = 1'b0;
        snap  = req_log.size();
        idle(30);
        check("post_reset_no_req", req_log.size() - snap, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
